// File: rtl/c16_sound.sv
// c16_sound: four-channel tone/noise synthesizer fed by the core's sound
// register-write port; emits a signed 16-bit PCM sample once per tick.

module c16_sound_chan (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              wen,
    input  logic [1:0]        w_param,
    input  logic [15:0]       w_val,
    output logic              bit_out,
    output logic signed [8:0] contrib
);

    logic [15:0] inc;
    logic [15:0] duty;
    logic [7:0]  vol;
    logic [1:0]  ctl;
    logic [15:0] phase;
    logic [15:0] lfsr;

    logic [16:0] phase_sum;
    logic [15:0] lfsr_next;
    logic        raw;
    logic        en;

    assign en        = ctl[0];
    assign phase_sum = {1'b0, phase} + {1'b0, inc};
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign raw       = ctl[1] ? lfsr[0] : (phase < duty);
    assign bit_out   = en & raw;

    always_comb begin
        contrib = '0;
        if (en) begin
            if (raw) begin
                contrib = $signed({1'b0, vol});
            end else begin
                contrib = -$signed({1'b0, vol});
            end
        end
    end

    // a ctl write lands after the tick update so its clear/reseed wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inc   <= '0;
            duty  <= 16'h8000;
            vol   <= '0;
            ctl   <= '0;
            phase <= '0;
            lfsr  <= 16'h0001;
        end else begin
            if (tick) begin
                phase <= phase_sum[15:0];
                if (phase_sum[16]) begin
                    lfsr <= lfsr_next;
                end
            end
            if (wen) begin
                unique case (w_param)
                    2'd0: inc  <= w_val;
                    2'd1: duty <= w_val;
                    2'd2: vol  <= w_val[7:0];
                    2'd3: begin
                        ctl   <= w_val[1:0];
                        phase <= '0;
                        lfsr  <= 16'h0001;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

module c16_sound #(
    parameter int unsigned SAMPLE_DIV = 1042
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        snd_wen,
    input  logic [1:0]  w_param,
    input  logic [10:0] w_index,
    input  logic [15:0] w_val,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic [3:0]  chan_out
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0]       div_cnt;
    logic              tick;
    logic [3:0]        bits;
    logic signed [8:0] contrib [4];
    logic signed [10:0] sum;
    logic [8:0]        unused_index;

    // upper index bits alias onto the four channels
    assign unused_index = w_index[10:2];
    assign tick         = (div_cnt == DIV_LAST);

    for (genvar n = 0; n < 4; n++) begin : g_chan
        logic sel;
        assign sel = snd_wen && (w_index[1:0] == 2'(n));

        c16_sound_chan u_chan (
            .clk     (clk),
            .resetn  (resetn),
            .tick    (tick),
            .wen     (sel),
            .w_param (w_param),
            .w_val   (w_val),
            .bit_out (bits[n]),
            .contrib (contrib[n])
        );
    end

    always_comb begin
        sum = '0;
        for (int n = 0; n < 4; n++) begin
            sum = sum + {{2{contrib[n][8]}}, contrib[n]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            chan_out     <= '0;
        end else begin
            sample_valid <= tick;
            if (tick) begin
                div_cnt  <= '0;
                sample   <= {sum, 5'b00000};
                chan_out <= bits;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/c16_sound.md
# c16_sound

Four-channel tone/noise synthesizer that consumes the CPU's sound register-write port (`snd_wen`, `w_param`, `w_index`, `w_val`) and produces a signed 16-bit PCM sample stream. It sits directly downstream of the c16 core's store path. Its output feeds the audio codec serializer. Each channel is a 16-bit phase accumulator with programmable duty, volume, and an optional LFSR noise mode; the four channels are summed once per sample tick.

## Interface
- `SAMPLE_DIV`, default 1042: clock cycles per sample tick (50 MHz / 48 kHz); legal range 2..65535.
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `snd_wen`  in  1  single-cycle write strobe from the core.
- `w_param`  in  2  register select within a channel.
- `w_index`  in  11  channel select; only [1:0] used, [10:2] ignored (aliases).
- `w_val`  in  16  write data.
- `sample`  out  16  signed mixed sample, two's complement.
- `sample_valid`  out  1  one-cycle pulse; `sample` is new in that cycle.
- `chan_out`  out  4  per-channel raw output bit captured with `sample` (bit n = channel n).

## Operation
- Per-channel registers, selected by `w_param` and written when `snd_wen`=1:
  - 0 `inc`[15:0]: phase increment. Reset value 0.
  - 1 `duty`[15:0]: high-threshold. Reset value 0x8000.
  - 2 `vol`[7:0]: from `w_val`[7:0]; [15:8] ignored. Reset value 0.
  - 3 `ctl`[1:0]: bit0 enable, bit1 noise mode; [15:2] ignored. Reset value 0. Any write to `ctl` also clears `phase` to 0 and reseeds `lfsr` to 0x0001.
- Internal per-channel state:
  - `phase`[15:0], reset value 0.
  - `lfsr`[15:0], reset value 0x0001.
- Prescaler `div_cnt` counts 0..SAMPLE_DIV-1 and wraps. A tick occurs in the cycle where `div_cnt`==SAMPLE_DIV-1.
- Channel bit `b`:
  - tone mode (ctl[1]=0): `b` = (`phase` < `duty`), unsigned compare.
  - noise mode (ctl[1]=1): `b` = `lfsr`[0].
- Channel contribution: disabled → 0; enabled → +`vol` if `b`=1, else −`vol`. Contribution is a 9-bit signed value.
- Mix:
  - `sum` = sum of the 4 contributions, 11-bit signed, range ±1020.
  - `sample` = `sum` << 5, sign-extended to 16 bits, range ±32640. No saturation is needed.
- On a tick, all of the following happen in the same edge:
  - `sample`, `chan_out` ← mix computed from pre-edge register/state values.
  - `sample_valid` ← 1.
  - each channel: `phase` ← `phase` + `inc` (mod 2^16). The update happens whether or not the channel is enabled.
  - if that addition carries out of bit 15, `lfsr` advances one Galois step: `lfsr` ← (`lfsr`>>1) ^ (`lfsr`[0] ? 0xB400 : 0).
- Simultaneous write and tick:
  - The mix and accumulate use the pre-write values.
  - The written register takes its new value.
  - A `ctl` write's clear/reseed of `phase` and `lfsr` overrides the tick update.
- Only one register is written per cycle.

## Timing
- Write latency: 1 cycle. A value written at edge N is used by a tick at edge N+1 or later.
- The first tick after reset release occurs at edge SAMPLE_DIV. The first `sample_valid` is high for the cycle following that edge. Thereafter pulses occur every SAMPLE_DIV cycles, exactly one cycle wide.
- `sample` and `chan_out` hold their value between pulses.
- Reset values of outputs: `sample`=0, `sample_valid`=0, `chan_out`=0.
- Asserting `resetn` mid-operation immediately forces all outputs and state to their reset values, including `div_cnt`=0, independent of `clk`.
- No backpressure: the consumer must take `sample` while `sample_valid` is high.

## Test plan
All scenarios use SAMPLE_DIV=4.
1. **Reset and tick cadence.** Release reset, no writes. Required: `sample_valid` pulses at edges 4, 8, 12, …, each one cycle wide. `sample`=0 and `chan_out`=0 throughout.
2. **Tone.** Write ch0: inc=0x4000, duty=0x8000, vol=100, then ctl=0x0001. Required: successive samples are 3200, 3200, −3200, −3200, repeating, with `chan_out`[0] = 1, 1, 0, 0.
3. **Full-scale mix.** All four channels: vol=255, inc=0, enabled.
   - duty=0xFFFF: every sample = 32640, `chan_out`=0xF.
   - duty=0: every sample = −32640, `chan_out`=0x0.
4. **Noise.** Write ch1: inc=0x8000, vol=10, then ctl=0x0003. Required: samples are +320, +320, −320, −320. `lfsr` reads 0xB400 after the second tick. `w_index`=0x005 must write ch1 (alias check).
5. **Write ignored and tick collision.**
   - `vid_wen`-only traffic, or `w_val` changes with `snd_wen`=0: no register changes.
   - `ctl` write in the same cycle as a tick: that sample reflects pre-write state, and `phase` is 0 afterwards.
6. **Asynchronous reset.** Drop `resetn` between clock edges during scenario 2. Required: `sample`, `sample_valid`, `chan_out` go to 0 before the next edge. After release, the channel is silent until reprogrammed.
